axis_pattern_gen: RTL and testbench
===================================

AXIS_PATTERN_GEN -- requirements
Module: axis_pattern_gen

Interface
REQ-001 Parameters SHALL be: STREAM_WIDTH_DATA, default 64, TDATA width; STREAM_WIDTH_DS, default STREAM_WIDTH_DATA/8, TSTRB/TKEEP width; STREAM_WIDTH_TID, default 8, TID width; STREAM_WIDTH_TDEST, default 3, TDEST width; STREAM_WIDTH_TUSER, default 1, TUSER width.
REQ-002 Ports SHALL be (name, direction, width, meaning), one clock, reset asynchronous and active-low:
- ACLK  in  1  clock, all logic rising-edge
- ARESETn  in  1  asynchronous active-low reset
- start  in  1  single-cycle request to begin a run
- num_packets  in  16  packets per run
- pkt_len  in  16  beats per packet
- mode  in  1  0 = incrementing counter data, 1 = LFSR data
- seed  in  64  initial data value / LFSR state
- cfg_tid  in  STREAM_WIDTH_TID  TID for the run
- cfg_tdest  in  STREAM_WIDTH_TDEST  TDEST for the run
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- M_TREADY  in  1  downstream ready (feeds encryptor S side)
- M_TVALID  out  1  beat valid
- M_TDATA  out  STREAM_WIDTH_DATA  beat data
- M_TSTRB  out  STREAM_WIDTH_DS  all ones while M_TVALID
- M_TKEEP  out  STREAM_WIDTH_DS  all ones while M_TVALID
- M_TLAST  out  1  last beat of packet
- M_TID  out  STREAM_WIDTH_TID  latched cfg_tid
- M_TDEST  out  STREAM_WIDTH_TDEST  latched cfg_tdest
- M_TUSER  out  STREAM_WIDTH_TUSER  bit0 = first beat of packet, other bits 0

Function
REQ-003 FSM states SHALL be IDLE, RUN, FINISH; IDLE->RUN on start in IDLE with num_packets!=0; IDLE->FINISH on start with num_packets==0; RUN->FINISH on handshake of last beat of last packet; FINISH->IDLE unconditionally next cycle.
REQ-004 On start in IDLE, num_packets, pkt_len, mode, seed, cfg_tid, cfg_tdest SHALL be latched; later changes SHALL NOT affect the run.
REQ-005 start while not IDLE SHALL be ignored.
REQ-006 pkt_len==0 SHALL be treated as 1.
REQ-007 Latency: start at edge N SHALL give M_TVALID=1 after edge N+1 (throttle disabled).
REQ-008 A beat SHALL transfer when M_TVALID&M_TREADY at a rising edge; once asserted, M_TVALID and all M_T* payload SHALL hold stable until handshake.
REQ-009 Without throttle, M_TVALID SHALL stay high in RUN including back-to-back packets (no bubble at packet boundaries).
REQ-010 mode 0: beat k (0-based, counted across the run) SHALL carry seed+k modulo 2^64.
REQ-011 mode 1: first beat SHALL carry seed (seed 0 replaced by 64'h1); each subsequent beat SHALL carry the previous value advanced one step of Galois LFSR x^64+x^63+x^61+x^60+1.
REQ-012 M_TLAST SHALL be 1 on beat pkt_len-1 of each packet; M_TUSER[0] SHALL be 1 on beat 0 of each packet.
REQ-013 busy SHALL be 1 in RUN and FINISH; done SHALL be 1 exactly in FINISH.
REQ-014 Beat and packet counters SHALL be 16-bit, wrap-free within legal ranges; up to 65535x65535 beats per run.

Reset
REQ-015 ARESETn low SHALL immediately force IDLE, M_TVALID=0, M_TLAST=0, M_TUSER=0, M_TDATA=0, M_TSTRB=0, M_TKEEP=0, M_TID=0, M_TDEST=0, busy=0, done=0, counters 0, throttle LFSR 16'hACE1.
REQ-016 Reset mid-packet SHALL abandon the run with no further beats and no done pulse.

Configuration
REQ-017 With THROTTLE_EN defined, a 16-bit LFSR (x^16+x^14+x^13+x^11+1) SHALL advance every cycle and, when its bit0 is 1, suppress raising M_TVALID for a new beat that cycle; an already-asserted M_TVALID SHALL never be dropped.
REQ-018 Without THROTTLE_EN, the throttle LFSR SHALL not exist and M_TVALID SHALL follow REQ-009.

Structure
REQ-019 Package axis_gen_pkg SHALL hold FSM state encoding, LFSR64 polynomial/tap constant, LFSR16 polynomial and reset seed constants.
REQ-020 Sub-module axis_lfsr64 (64-bit Galois next-state, combinational) SHALL be instantiated once.

Verification
REQ-021 Counter: mode=0, seed=64'h100, num_packets=2, pkt_len=4, M_TREADY=1 -> 8 beats 0x100..0x107 on consecutive cycles, TLAST on beats 3 and 7, TUSER[0] on beats 0 and 4, done one cycle after beat 7.
REQ-022 Backpressure: as REQ-021 with M_TREADY low for 3 cycles at beat 2 -> beat 2 (0x102) held stable 3 cycles, total sequence unchanged.
REQ-023 LFSR: mode=1, seed=0, num_packets=1, pkt_len=3 -> beats 64'h1, then two successive LFSR steps matching a bench reference model; TLAST on beat 2.
REQ-024 Edge cases: num_packets=0 -> no TVALID, done two cycles after start; pkt_len=0, num_packets=3 -> 3 beats, each with TLAST=1 and TUSER[0]=1.
REQ-025 Reset mid-run: assert ARESETn low at beat 5 of 8 -> TVALID low immediately, no done; new start after release restarts from seed.
REQ-026 THROTTLE_EN build, 64-beat run through encryptor/decryptor with check_stream-style comparison -> gaps in TVALID, zero data errors, TVALID never drops without handshake.

Source files
------------

// File: rtl/axis_gen_pkg.sv
// rtl/axis_gen_pkg.sv - shared types and constants for the AXI-Stream pattern generator
// Contents: FSM state encoding, 64-bit data LFSR taps, 16-bit throttle LFSR taps and reset seed.
package axis_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } gen_state_t;

    // Right-shifting Galois form of x^64+x^63+x^61+x^60+1: term x^n toggles bit n-1.
    localparam logic [63:0] LFSR64_TAPS = 64'hD800_0000_0000_0000;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
    localparam logic [15:0] LFSR16_TAPS = 16'hB400;
    localparam logic [15:0] LFSR16_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? LFSR16_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/axis_lfsr64.sv
// rtl/axis_lfsr64.sv - combinational next-state of the 64-bit Galois data LFSR
// Ports: state_i current LFSR value, next_o value one step later.
module axis_lfsr64
    import axis_gen_pkg::*;
(
    input  logic [63:0] state_i,
    output logic [63:0] next_o
);

    assign next_o = (state_i >> 1) ^ (state_i[0] ? LFSR64_TAPS : 64'h0);

endmodule

// File: rtl/axis_pattern_gen.sv
// rtl/axis_pattern_gen.sv - AXI-Stream packet generator with counter or LFSR payload
// Ports: ACLK/ARESETn (async active-low), start + run config (num_packets, pkt_len, mode,
// seed, cfg_tid, cfg_tdest), busy/done status, AXI-Stream master M_T*.
// Optional build macro THROTTLE_EN: pseudo-random gaps inserted before new beats.
module axis_pattern_gen
    import axis_gen_pkg::*;
#(
    parameter int STREAM_WIDTH_DATA  = 64,
    parameter int STREAM_WIDTH_DS    = STREAM_WIDTH_DATA / 8,
    parameter int STREAM_WIDTH_TID   = 8,
    parameter int STREAM_WIDTH_TDEST = 3,
    parameter int STREAM_WIDTH_TUSER = 1
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic                          start,
    input  logic [15:0]                   num_packets,
    input  logic [15:0]                   pkt_len,
    input  logic                          mode,
    input  logic [63:0]                   seed,
    input  logic [STREAM_WIDTH_TID-1:0]   cfg_tid,
    input  logic [STREAM_WIDTH_TDEST-1:0] cfg_tdest,
    output logic                          busy,
    output logic                          done,
    input  logic                          M_TREADY,
    output logic                          M_TVALID,
    output logic [STREAM_WIDTH_DATA-1:0]  M_TDATA,
    output logic [STREAM_WIDTH_DS-1:0]    M_TSTRB,
    output logic [STREAM_WIDTH_DS-1:0]    M_TKEEP,
    output logic                          M_TLAST,
    output logic [STREAM_WIDTH_TID-1:0]   M_TID,
    output logic [STREAM_WIDTH_TDEST-1:0] M_TDEST,
    output logic [STREAM_WIDTH_TUSER-1:0] M_TUSER
);

    gen_state_t                  state_q, state_d;
    logic [15:0]                 np_q, np_d;
    logic [15:0]                 len_q, len_d;
    logic                        mode_q, mode_d;
    logic [63:0]                 val_q, val_d;      // value of the next beat to launch
    logic [15:0]                 beat_q, beat_d;    // index in packet of the next beat
    logic [15:0]                 pkt_q, pkt_d;      // packet index of the next beat
    logic                        tvalid_q, tvalid_d;
    logic                        tlast_q, tlast_d;
    logic                        tuser_q, tuser_d;
    logic                        final_q, final_d;  // presented beat is the last of the run
    logic [63:0]                 data_q, data_d;
    logic [STREAM_WIDTH_TID-1:0]   tid_q, tid_d;
    logic [STREAM_WIDTH_TDEST-1:0] tdest_q, tdest_d;
    logic [63:0]                 val_lfsr;
    logic                        stall;
    logic                        launch;
    logic                        hs;

`ifdef THROTTLE_EN
    logic [15:0]                 thr_q, thr_d;
`endif

    axis_lfsr64 u_lfsr64 (
        .state_i (val_q),
        .next_o  (val_lfsr)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q  <= ST_IDLE;
            np_q     <= '0;
            len_q    <= '0;
            mode_q   <= 1'b0;
            val_q    <= '0;
            beat_q   <= '0;
            pkt_q    <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
            final_q  <= 1'b0;
            data_q   <= '0;
            tid_q    <= '0;
            tdest_q  <= '0;
`ifdef THROTTLE_EN
            thr_q    <= LFSR16_SEED;
`endif
        end else begin
            state_q  <= state_d;
            np_q     <= np_d;
            len_q    <= len_d;
            mode_q   <= mode_d;
            val_q    <= val_d;
            beat_q   <= beat_d;
            pkt_q    <= pkt_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tuser_q  <= tuser_d;
            final_q  <= final_d;
            data_q   <= data_d;
            tid_q    <= tid_d;
            tdest_q  <= tdest_d;
`ifdef THROTTLE_EN
            thr_q    <= thr_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        np_d     = np_q;
        len_d    = len_q;
        mode_d   = mode_q;
        val_d    = val_q;
        beat_d   = beat_q;
        pkt_d    = pkt_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;
        final_d  = final_q;
        data_d   = data_q;
        tid_d    = tid_q;
        tdest_d  = tdest_q;
        launch   = 1'b0;
        hs       = tvalid_q & M_TREADY;
`ifdef THROTTLE_EN
        thr_d    = lfsr16_next(thr_q);
        stall    = thr_q[0];
`else
        stall    = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    np_d    = num_packets;
                    len_d   = (pkt_len == 16'd0) ? 16'd1 : pkt_len;
                    mode_d  = mode;
                    // An all-zero LFSR would lock up, so seed 0 becomes 1 in LFSR mode.
                    val_d   = (mode && seed == 64'd0) ? 64'd1 : seed;
                    tid_d   = cfg_tid;
                    tdest_d = cfg_tdest;
                    beat_d  = '0;
                    pkt_d   = '0;
                    state_d = (num_packets != 16'd0) ? ST_RUN : ST_FINISH;
                end
            end
            ST_RUN: begin
                if (hs) begin
                    tvalid_d = 1'b0;
                    if (final_q) begin
                        state_d = ST_FINISH;
                    end
                end
                // A new beat may replace the presented one in the same cycle it is
                // accepted, which keeps packets back-to-back without a bubble.
                launch = (!tvalid_q || (hs && !final_q)) && !stall;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (launch) begin
            tvalid_d = 1'b1;
            data_d   = val_q;
            val_d    = mode_q ? val_lfsr : val_q + 64'd1;
            tlast_d  = (beat_q == len_q - 16'd1);
            tuser_d  = (beat_q == 16'd0);
            final_d  = tlast_d && (pkt_q == np_q - 16'd1);
            if (tlast_d) begin
                beat_d = '0;
                pkt_d  = pkt_q + 16'd1;
            end else begin
                beat_d = beat_q + 16'd1;
            end
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_FINISH);
    assign M_TVALID = tvalid_q;
    assign M_TDATA  = STREAM_WIDTH_DATA'(data_q);
    assign M_TSTRB  = {STREAM_WIDTH_DS{tvalid_q}};
    assign M_TKEEP  = {STREAM_WIDTH_DS{tvalid_q}};
    assign M_TLAST  = tlast_q;
    assign M_TID    = tid_q;
    assign M_TDEST  = tdest_q;
    assign M_TUSER  = STREAM_WIDTH_TUSER'(tuser_q);

endmodule

// File: tb/tb_axis_pattern_gen.sv
// tb/tb_axis_pattern_gen.sv - self-checking bench for axis_pattern_gen
module tb_axis_pattern_gen;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        start;
    logic [15:0] num_packets;
    logic [15:0] pkt_len;
    logic        mode;
    logic [63:0] seed;
    logic [7:0]  cfg_tid;
    logic [2:0]  cfg_tdest;
    logic        busy;
    logic        done;
    logic        M_TREADY;
    logic        M_TVALID;
    logic [63:0] M_TDATA;
    logic [7:0]  M_TSTRB;
    logic [7:0]  M_TKEEP;
    logic        M_TLAST;
    logic [7:0]  M_TID;
    logic [2:0]  M_TDEST;
    logic [0:0]  M_TUSER;

    axis_pattern_gen dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .start       (start),
        .num_packets (num_packets),
        .pkt_len     (pkt_len),
        .mode        (mode),
        .seed        (seed),
        .cfg_tid     (cfg_tid),
        .cfg_tdest   (cfg_tdest),
        .busy        (busy),
        .done        (done),
        .M_TREADY    (M_TREADY),
        .M_TVALID    (M_TVALID),
        .M_TDATA     (M_TDATA),
        .M_TSTRB     (M_TSTRB),
        .M_TKEEP     (M_TKEEP),
        .M_TLAST     (M_TLAST),
        .M_TID       (M_TID),
        .M_TDEST     (M_TDEST),
        .M_TUSER     (M_TUSER)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        user;
        logic [7:0]  tid;
        logic [2:0]  tdest;
        logic [7:0]  strb;
        logic [7:0]  keep;
        int          cyc;
    } beat_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor state, written only by the monitor.
    beat_t beats[$];
    int    cyc       = 0;
    int    done_cnt  = 0;
    int    done_cyc  = 0;
    int    busy_cnt  = 0;
    int    vis_cnt   = 0;
    int    hold_viol = 0;
    logic  prev_v    = 1'b0;
    logic  prev_r    = 1'b0;
    beat_t prev_b;

    // Expected stream and snapshots taken at each run start.
    beat_t exp_q[$];
    int    b0, d0, h0, v0, bz0, start_cyc;
    bit    timed_out;

    // Ready generation: 0 always ready, 1 random, 2 stall a chosen beat for stall_left cycles.
    int          ready_mode = 0;
    int          stall_left = 0;
    logic [63:0] stall_data = '0;

    always @(posedge ACLK) begin
        #1;
        case (ready_mode)
            1:       M_TREADY = ($urandom_range(0, 3) != 0);
            2: begin
                if (M_TVALID && M_TDATA == stall_data && stall_left > 0) begin
                    M_TREADY   = 1'b0;
                    stall_left = stall_left - 1;
                end else begin
                    M_TREADY = 1'b1;
                end
            end
            default: M_TREADY = 1'b1;
        endcase
    end

    // Negedge monitor: inputs are stable here and outputs show what the next edge samples.
    always @(negedge ACLK) begin
        beat_t cur;
        cur.data  = M_TDATA;
        cur.last  = M_TLAST;
        cur.user  = M_TUSER[0];
        cur.tid   = M_TID;
        cur.tdest = M_TDEST;
        cur.strb  = M_TSTRB;
        cur.keep  = M_TKEEP;
        cur.cyc   = cyc;
        cyc <= cyc + 1;
        if (!ARESETn) begin
            prev_v <= 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                if (!M_TVALID || cur.data !== prev_b.data || cur.last !== prev_b.last ||
                    cur.user !== prev_b.user || cur.tid !== prev_b.tid ||
                    cur.tdest !== prev_b.tdest) begin
                    hold_viol <= hold_viol + 1;
                end
            end
            if (M_TVALID && M_TREADY) beats.push_back(cur);
            if (M_TVALID) vis_cnt <= vis_cnt + 1;
            if (busy) busy_cnt <= busy_cnt + 1;
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            prev_v <= M_TVALID;
            prev_r <= M_TREADY;
            prev_b <= cur;
        end
    end

    // Reference LFSR step written from the polynomial's exponent list.
    function automatic logic [63:0] lfsr_ref(input logic [63:0] s);
        int          exps[4];
        logic [63:0] m;
        exps = '{64, 63, 61, 60};
        m = '0;
        foreach (exps[i]) m[exps[i] - 1] = 1'b1;
        return s[0] ? ((s >> 1) ^ m) : (s >> 1);
    endfunction

    task automatic build_expected(input int np, input int len, input bit md,
                                  input logic [63:0] sd, input logic [7:0] tid,
                                  input logic [2:0] tdest);
        int          eff;
        logic [63:0] v;
        beat_t       b;
        exp_q.delete();
        eff = (len == 0) ? 1 : len;
        v   = (md && sd == 64'd0) ? 64'd1 : sd;
        for (int k = 0; k < np * eff; k++) begin
            b.data  = md ? v : sd + 64'(k);
            b.last  = ((k % eff) == eff - 1);
            b.user  = ((k % eff) == 0);
            b.tid   = tid;
            b.tdest = tdest;
            b.strb  = 8'hFF;
            b.keep  = 8'hFF;
            b.cyc   = 0;
            exp_q.push_back(b);
            if (md) v = lfsr_ref(v);
        end
    endtask

    // Drive one run; config is scrambled and start re-pulsed after launch to prove latching.
    task automatic do_run(input int np, input int len, input bit md, input logic [63:0] sd,
                          input logic [7:0] tid, input logic [2:0] tdest);
        int n;
        @(posedge ACLK); #2;
        b0 = beats.size(); d0 = done_cnt; h0 = hold_viol; v0 = vis_cnt; bz0 = busy_cnt;
        num_packets = 16'(np); pkt_len = 16'(len); mode = md; seed = sd;
        cfg_tid = tid; cfg_tdest = tdest; start = 1'b1;
        start_cyc = cyc;
        @(posedge ACLK); #2;
        start = 1'b0;
        num_packets = 16'($urandom_range(1, 9)); pkt_len = 16'($urandom_range(1, 9));
        mode = ~md; seed = {$urandom, $urandom}; cfg_tid = ~tid; cfg_tdest = ~tdest;
        start = 1'b1;
        @(posedge ACLK); #2;
        start = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 4000) begin
            @(posedge ACLK); #2;
            n++;
        end
        timed_out = (done_cnt == d0);
        repeat (3) @(posedge ACLK);
        #2;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        repeat (3) @(posedge ACLK);
        #2;
        n_checks++; if (M_TVALID !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b want 0", M_TVALID); end
        n_checks++; if (M_TDATA !== 64'd0) begin n_fail++; $display("FAIL reset_tdata got %h want 0", M_TDATA); end
        n_checks++; if (M_TLAST !== 1'b0 || M_TUSER !== 1'b0) begin n_fail++; $display("FAIL reset_tlast_tuser got %b/%b want 0/0", M_TLAST, M_TUSER); end
        n_checks++; if (M_TSTRB !== 8'd0 || M_TKEEP !== 8'd0) begin n_fail++; $display("FAIL reset_strb_keep got %h/%h want 00/00", M_TSTRB, M_TKEEP); end
        n_checks++; if (M_TID !== 8'd0 || M_TDEST !== 3'd0) begin n_fail++; $display("FAIL reset_tid_tdest got %h/%h want 0/0", M_TID, M_TDEST); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done got %b/%b want 0/0", busy, done); end
        @(posedge ACLK); #2;
        ARESETn = 1'b1;
        repeat (2) @(posedge ACLK);
    endtask

    task automatic test_counter();
        ready_mode = 0;
        build_expected(2, 4, 1'b0, 64'h100, 8'h5A, 3'h5);
        do_run(2, 4, 1'b0, 64'h100, 8'h5A, 3'h5);
        n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL counter_timeout got done_seen=0 want 1"); end
        n_checks++; if (beats.size() - b0 !== 8) begin n_fail++; $display("FAIL counter_count got %0d want 8", beats.size() - b0); end
        if (beats.size() - b0 == 8) begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (beats[b0+i].data !== exp_q[i].data || beats[b0+i].last !== exp_q[i].last ||
                    beats[b0+i].user !== exp_q[i].user || beats[b0+i].tid !== exp_q[i].tid ||
                    beats[b0+i].tdest !== exp_q[i].tdest || beats[b0+i].strb !== 8'hFF ||
                    beats[b0+i].keep !== 8'hFF) begin
                    n_fail++;
                    $display("FAIL counter_beat%0d got d=%h l=%b u=%b id=%h de=%h s=%h want d=%h l=%b u=%b id=5a de=5 s=ff",
                             i, beats[b0+i].data, beats[b0+i].last, beats[b0+i].user, beats[b0+i].tid,
                             beats[b0+i].tdest, beats[b0+i].strb, exp_q[i].data, exp_q[i].last, exp_q[i].user);
                end
`ifndef THROTTLE_EN
                n_checks++;
                if (beats[b0+i].cyc !== start_cyc + 2 + i) begin
                    n_fail++;
                    $display("FAIL counter_timing_beat%0d got cycle %0d want %0d", i, beats[b0+i].cyc, start_cyc + 2 + i);
                end
`endif
            end
            n_checks++; if (done_cyc !== beats[b0+7].cyc + 1) begin n_fail++; $display("FAIL counter_done_cycle got %0d want %0d", done_cyc, beats[b0+7].cyc + 1); end
            n_checks++; if (busy_cnt - bz0 !== done_cyc - start_cyc) begin n_fail++; $display("FAIL counter_busy_cycles got %0d want %0d", busy_cnt - bz0, done_cyc - start_cyc); end
        end
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL counter_done_pulses got %0d want 1", done_cnt - d0); end
        n_checks++; if (hold_viol - h0 !== 0) begin n_fail++; $display("FAIL counter_hold got %0d violations want 0", hold_viol - h0); end
    endtask

    task automatic test_backpressure();
        ready_mode = 2; stall_data = 64'h102; stall_left = 3;
        build_expected(2, 4, 1'b0, 64'h100, 8'h11, 3'h2);
        do_run(2, 4, 1'b0, 64'h100, 8'h11, 3'h2);
        ready_mode = 0;
        n_checks++; if (beats.size() - b0 !== 8) begin n_fail++; $display("FAIL bp_count got %0d want 8", beats.size() - b0); end
        if (beats.size() - b0 == 8) begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (beats[b0+i].data !== exp_q[i].data || beats[b0+i].last !== exp_q[i].last ||
                    beats[b0+i].user !== exp_q[i].user) begin
                    n_fail++;
                    $display("FAIL bp_beat%0d got d=%h l=%b u=%b want d=%h l=%b u=%b", i, beats[b0+i].data,
                             beats[b0+i].last, beats[b0+i].user, exp_q[i].data, exp_q[i].last, exp_q[i].user);
                end
            end
        end
`ifndef THROTTLE_EN
        n_checks++; if (vis_cnt - v0 !== 11) begin n_fail++; $display("FAIL bp_valid_cycles got %0d want 11", vis_cnt - v0); end
`endif
        n_checks++; if (hold_viol - h0 !== 0) begin n_fail++; $display("FAIL bp_hold got %0d violations want 0", hold_viol - h0); end
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL bp_done_pulses got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_lfsr();
        logic [63:0] want[3];
        want = '{64'h1, 64'hD800_0000_0000_0000, 64'h6C00_0000_0000_0000};
        ready_mode = 0;
        build_expected(1, 3, 1'b1, 64'h0, 8'h01, 3'h1);
        do_run(1, 3, 1'b1, 64'h0, 8'h01, 3'h1);
        n_checks++; if (beats.size() - b0 !== 3) begin n_fail++; $display("FAIL lfsr_count got %0d want 3", beats.size() - b0); end
        if (beats.size() - b0 == 3) begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (beats[b0+i].data !== exp_q[i].data || beats[b0+i].data !== want[i]) begin
                    n_fail++;
                    $display("FAIL lfsr_beat%0d got %h want %h", i, beats[b0+i].data, exp_q[i].data);
                end
                n_checks++;
                if (beats[b0+i].last !== (i == 2) || beats[b0+i].user !== (i == 0)) begin
                    n_fail++;
                    $display("FAIL lfsr_flags%0d got l=%b u=%b want l=%b u=%b", i, beats[b0+i].last, beats[b0+i].user, i == 2, i == 0);
                end
            end
        end
    endtask

    task automatic test_edge();
        ready_mode = 0;
        do_run(0, 4, 1'b0, 64'h55, 8'h00, 3'h0);
        n_checks++; if (vis_cnt - v0 !== 0) begin n_fail++; $display("FAIL np0_tvalid got %0d valid cycles want 0", vis_cnt - v0); end
        n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL np0_done_pulses got %0d want 1", done_cnt - d0); end
        n_checks++;
        if (done_cyc < start_cyc + 1 || done_cyc > start_cyc + 2) begin
            n_fail++;
            $display("FAIL np0_done_cycle got %0d want %0d..%0d", done_cyc, start_cyc + 1, start_cyc + 2);
        end
        build_expected(3, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 8'h22, 3'h3);
        do_run(3, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 8'h22, 3'h3);
        n_checks++; if (beats.size() - b0 !== 3) begin n_fail++; $display("FAIL len0_count got %0d want 3", beats.size() - b0); end
        if (beats.size() - b0 == 3) begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (beats[b0+i].last !== 1'b1 || beats[b0+i].user !== 1'b1 || beats[b0+i].data !== exp_q[i].data) begin
                    n_fail++;
                    $display("FAIL len0_beat%0d got d=%h l=%b u=%b want d=%h l=1 u=1", i, beats[b0+i].data,
                             beats[b0+i].last, beats[b0+i].user, exp_q[i].data);
                end
            end
        end
    endtask

    task automatic test_random();
        int          np, len;
        bit          md;
        logic [63:0] sd;
        logic [7:0]  tid;
        logic [2:0]  tdest;
        for (int it = 0; it < 5; it++) begin
            ready_mode = 1;
            np = $urandom_range(1, 4); len = $urandom_range(0, 6); md = 1'($urandom_range(0, 1));
            sd = {$urandom, $urandom}; tid = 8'($urandom); tdest = 3'($urandom);
            build_expected(np, len, md, sd, tid, tdest);
            do_run(np, len, md, sd, tid, tdest);
            n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL rand%0d_timeout got done_seen=0 want 1", it); end
            n_checks++;
            if (beats.size() - b0 !== exp_q.size()) begin
                n_fail++;
                $display("FAIL rand%0d_count got %0d want %0d", it, beats.size() - b0, exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    n_checks++;
                    if (beats[b0+i].data !== exp_q[i].data || beats[b0+i].last !== exp_q[i].last ||
                        beats[b0+i].user !== exp_q[i].user || beats[b0+i].tid !== tid ||
                        beats[b0+i].tdest !== tdest) begin
                        n_fail++;
                        $display("FAIL rand%0d_beat%0d got d=%h l=%b u=%b want d=%h l=%b u=%b", it, i,
                                 beats[b0+i].data, beats[b0+i].last, beats[b0+i].user,
                                 exp_q[i].data, exp_q[i].last, exp_q[i].user);
                    end
                end
            end
            n_checks++; if (hold_viol - h0 !== 0) begin n_fail++; $display("FAIL rand%0d_hold got %0d violations want 0", it, hold_viol - h0); end
            n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL rand%0d_done got %0d pulses want 1", it, done_cnt - d0); end
        end
        ready_mode = 0;
    endtask

    task automatic test_reset_mid();
        logic [63:0] sd;
        int          n;
        ready_mode = 0;
        sd = {$urandom, $urandom};
        @(posedge ACLK); #2;
        b0 = beats.size(); d0 = done_cnt;
        num_packets = 16'd2; pkt_len = 16'd4; mode = 1'b0; seed = sd;
        cfg_tid = 8'h7; cfg_tdest = 3'h7; start = 1'b1;
        @(posedge ACLK); #2;
        start = 1'b0;
        n = 0;
        while (!(M_TVALID && M_TDATA == sd + 64'd5) && n < 200) begin
            @(posedge ACLK); #2;
            n++;
        end
        n_checks++; if (n >= 200) begin n_fail++; $display("FAIL rmid_reach_beat5 got timeout want beat 5 visible"); end
        ARESETn = 1'b0;
        #1;
        n_checks++; if (M_TVALID !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_immediate got tvalid=%b busy=%b want 0/0", M_TVALID, busy); end
        repeat (2) @(posedge ACLK);
        #2;
        ARESETn = 1'b1;
        repeat (10) @(posedge ACLK);
        #2;
        n_checks++; if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL rmid_no_done got %0d pulses want 0", done_cnt - d0); end
        n_checks++; if (beats.size() - b0 !== 5) begin n_fail++; $display("FAIL rmid_beats got %0d want 5", beats.size() - b0); end
        do_run(2, 4, 1'b0, sd, 8'h7, 3'h7);
        n_checks++; if (beats.size() - b0 !== 8) begin n_fail++; $display("FAIL rmid_restart_count got %0d want 8", beats.size() - b0); end
        if (beats.size() - b0 == 8) begin
            n_checks++; if (beats[b0].data !== sd) begin n_fail++; $display("FAIL rmid_restart_first got %h want %h", beats[b0].data, sd); end
            n_checks++; if (beats[b0+7].data !== sd + 64'd7) begin n_fail++; $display("FAIL rmid_restart_last got %h want %h", beats[b0+7].data, sd + 64'd7); end
        end
    endtask

    initial begin
        ARESETn = 1'b0; start = 1'b0; num_packets = '0; pkt_len = '0; mode = 1'b0;
        seed = '0; cfg_tid = '0; cfg_tdest = '0; M_TREADY = 1'b1;
        test_reset();
        test_counter();
        test_backpressure();
        test_lfsr();
        test_edge();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
